// File: rtl/alu_pkg.sv
// Shared definitions for the alu block and its command-side sequencer.
package alu_pkg;

  localparam int ALU_DATA_WIDTH   = 4;
  localparam int ALU_OPCODE_WIDTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_COMMIT
  } seq_state_t;

endpackage

// File: rtl/alu_regfile.sv
// Operand register file: two combinational read ports, an ALU write-back port
// and a direct load port, with write-back taking priority on a shared index.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DATA_WIDTH,
  parameter int NUM_REGS   = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [$clog2(NUM_REGS)-1:0] rd_addr0,
  output logic [DATA_WIDTH-1:0]       rd_data0,
  input  logic [$clog2(NUM_REGS)-1:0] rd_addr1,
  output logic [DATA_WIDTH-1:0]       rd_data1,
  input  logic                        wb_en,
  input  logic [$clog2(NUM_REGS)-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0]       wb_data,
  input  logic                        ld_en,
  input  logic [$clog2(NUM_REGS)-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0]       ld_data
);

  localparam int AW = $clog2(NUM_REGS);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // Both ports may write different entries in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wb_en && (wb_addr == AW'(i))) begin
          regs[i] <= wb_data;
        end else if (ld_en && (ld_addr == AW'(i))) begin
          regs[i] <= ld_data;
        end
      end
    end
  end

  assign rd_data0 = regs[rd_addr0];
  assign rd_data1 = regs[rd_addr1];

endmodule

// File: rtl/alu_sequencer.sv
// Sequences register-to-register instructions through a fixed-latency ALU,
// one instruction at a time, writing each result back to the register file.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH   = ALU_DATA_WIDTH,
  parameter int OPCODE_WIDTH = ALU_OPCODE_WIDTH,
  parameter int NUM_REGS     = 4,
  parameter int ALU_LATENCY  = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        instr_valid,
  output logic                        instr_ready,
  input  logic [OPCODE_WIDTH-1:0]     instr_op,
  input  logic [$clog2(NUM_REGS)-1:0] instr_dst,
  input  logic [$clog2(NUM_REGS)-1:0] instr_src0,
  input  logic [$clog2(NUM_REGS)-1:0] instr_src1,
  input  logic                        ld_en,
  input  logic [$clog2(NUM_REGS)-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0]       ld_data,
  output logic                        alu_enable,
  output logic [OPCODE_WIDTH-1:0]     alu_op_code,
  output logic [DATA_WIDTH-1:0]       alu_op0,
  output logic [DATA_WIDTH-1:0]       alu_op1,
  input  logic [DATA_WIDTH-1:0]       alu_out,
  output logic                        res_valid,
  output logic [$clog2(NUM_REGS)-1:0] res_dst,
  output logic [DATA_WIDTH-1:0]       res_data
);

  localparam int AW = $clog2(NUM_REGS);
  localparam int CW = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(ALU_LATENCY - 1);

  seq_state_t state;
  seq_state_t state_next;

  logic [CW-1:0]         wait_cnt;
  logic [AW-1:0]         dst_q;
  logic [DATA_WIDTH-1:0] src0_data;
  logic [DATA_WIDTH-1:0] src1_data;
  logic                  accept;
  logic                  wait_last;

  logic                    ready_d;
  logic                    enable_d;
  logic [OPCODE_WIDTH-1:0] op_code_d;
  logic [DATA_WIDTH-1:0]   op0_d;
  logic [DATA_WIDTH-1:0]   op1_d;
  logic                    res_valid_d;
  logic [AW-1:0]           res_dst_d;
  logic [DATA_WIDTH-1:0]   res_data_d;

  assign accept    = instr_valid && instr_ready;
  assign wait_last = (state == ST_WAIT) && (wait_cnt == LAST_CNT);

  alu_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .rd_addr0 (instr_src0),
    .rd_data0 (src0_data),
    .rd_addr1 (instr_src1),
    .rd_data1 (src1_data),
    .wb_en    (wait_last),
    .wb_addr  (dst_q),
    .wb_data  (alu_out),
    .ld_en    (ld_en),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (accept) state_next = ST_ISSUE;
      ST_ISSUE:  state_next = ST_WAIT;
      ST_WAIT:   if (wait_last) state_next = ST_COMMIT;
      ST_COMMIT: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Next values for the registered outputs; operands hold until the next acceptance.
  always_comb begin
    ready_d     = (state_next == ST_IDLE);
    enable_d    = (state == ST_IDLE) && accept;
    op_code_d   = alu_op_code;
    op0_d       = alu_op0;
    op1_d       = alu_op1;
    res_valid_d = wait_last;
    res_dst_d   = res_dst;
    res_data_d  = res_data;
    if ((state == ST_IDLE) && accept) begin
      op_code_d = instr_op;
      op0_d     = src0_data;
      op1_d     = src1_data;
    end
    if (wait_last) begin
      res_dst_d  = dst_q;
      res_data_d = alu_out;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_ready <= 1'b0;
      alu_enable  <= 1'b0;
      alu_op_code <= '0;
      alu_op0     <= '0;
      alu_op1     <= '0;
      res_valid   <= 1'b0;
      res_dst     <= '0;
      res_data    <= '0;
      wait_cnt    <= '0;
      dst_q       <= '0;
    end else begin
      instr_ready <= ready_d;
      alu_enable  <= enable_d;
      alu_op_code <= op_code_d;
      alu_op0     <= op0_d;
      alu_op1     <= op1_d;
      res_valid   <= res_valid_d;
      res_dst     <= res_dst_d;
      res_data    <= res_data_d;
      if (state == ST_ISSUE) begin
        wait_cnt <= '0;
      end else if (state == ST_WAIT) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
      if (accept) begin
        dst_q <= instr_dst;
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a default build and a latency-3 / 8-register build,
// each driving a behavioural ALU, with results checked through a scoreboard.
module tb_alu_sequencer;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;
  localparam logic [1:0] OP_OR  = 2'd3;

  typedef struct packed {
    logic       valid;
    logic [1:0] op;
    logic [2:0] dst;
    logic [2:0] s0;
    logic [2:0] s1;
    logic       ld_en;
    logic [2:0] ld_addr;
    logic [3:0] ld_data;
  } drv_t;

  typedef struct packed {
    logic       ready;
    logic       enable;
    logic [1:0] op_code;
    logic [3:0] op0;
    logic [3:0] op1;
    logic       res_valid;
    logic [2:0] res_dst;
    logic [3:0] res_data;
  } obs_t;

  typedef struct packed {
    logic       do_ld;
    logic [2:0] la;
    logic [3:0] ld;
    logic       do_ins;
    logic [1:0] op;
    logic [2:0] dst;
    logic [2:0] s0;
    logic [2:0] s1;
    logic [3:0] e0;
    logic [3:0] e1;
    logic [3:0] er;
  } vec_t;

  typedef struct {
    int          unit;
    logic [31:0] dst;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic clk;
  logic reset;
  drv_t drv [2];
  int   cycle = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   last_acc = 0;
  exp_t sb [$];

  logic       a_ready, a_enable, a_res_valid;
  logic [1:0] a_op_code, a_res_dst;
  logic [3:0] a_op0, a_op1, a_out, a_res_data;
  logic [1:0] a_dst, a_s0, a_s1, a_ld_addr;

  logic       b_ready, b_enable, b_res_valid;
  logic [1:0] b_op_code;
  logic [2:0] b_res_dst;
  logic [3:0] b_op0, b_op1, b_out, b_res_data;
  logic [3:0] b_s0_pipe, b_s1_pipe, b_s2_pipe;

  assign a_dst     = drv[0].dst[1:0];
  assign a_s0      = drv[0].s0[1:0];
  assign a_s1      = drv[0].s1[1:0];
  assign a_ld_addr = drv[0].ld_addr[1:0];

  alu_sequencer #(.DATA_WIDTH(4), .OPCODE_WIDTH(2), .NUM_REGS(4), .ALU_LATENCY(1)) dut_a (
    .clk(clk), .reset(reset),
    .instr_valid(drv[0].valid), .instr_ready(a_ready), .instr_op(drv[0].op),
    .instr_dst(a_dst), .instr_src0(a_s0), .instr_src1(a_s1),
    .ld_en(drv[0].ld_en), .ld_addr(a_ld_addr), .ld_data(drv[0].ld_data),
    .alu_enable(a_enable), .alu_op_code(a_op_code), .alu_op0(a_op0), .alu_op1(a_op1),
    .alu_out(a_out), .res_valid(a_res_valid), .res_dst(a_res_dst), .res_data(a_res_data)
  );

  alu_sequencer #(.DATA_WIDTH(4), .OPCODE_WIDTH(2), .NUM_REGS(8), .ALU_LATENCY(3)) dut_b (
    .clk(clk), .reset(reset),
    .instr_valid(drv[1].valid), .instr_ready(b_ready), .instr_op(drv[1].op),
    .instr_dst(drv[1].dst), .instr_src0(drv[1].s0), .instr_src1(drv[1].s1),
    .ld_en(drv[1].ld_en), .ld_addr(drv[1].ld_addr), .ld_data(drv[1].ld_data),
    .alu_enable(b_enable), .alu_op_code(b_op_code), .alu_op0(b_op0), .alu_op1(b_op1),
    .alu_out(b_out), .res_valid(b_res_valid), .res_dst(b_res_dst), .res_data(b_res_data)
  );

  function automatic logic [3:0] alu_f(input logic [1:0] op, input logic [3:0] x, input logic [3:0] y);
    case (op)
      OP_ADD:  return x + y;
      OP_SUB:  return x - y;
      OP_AND:  return x & y;
      default: return x | y;
    endcase
  endfunction

  // Behavioural ALUs: one-cycle result for build A, three-stage pipe for build B.
  always_ff @(posedge clk) begin
    if (a_enable) a_out <= alu_f(a_op_code, a_op0, a_op1);
  end

  always_ff @(posedge clk) begin
    if (b_enable) b_s0_pipe <= alu_f(b_op_code, b_op0, b_op1);
    b_s1_pipe <= b_s0_pipe;
    b_s2_pipe <= b_s1_pipe;
  end
  assign b_out = b_s2_pipe;

  function automatic obs_t obs(input int u);
    obs_t o;
    if (u == 0) o = '{a_ready, a_enable, a_op_code, a_op0, a_op1, a_res_valid, {1'b0, a_res_dst}, a_res_data};
    else        o = '{b_ready, b_enable, b_op_code, b_op0, b_op1, b_res_valid, b_res_dst, b_res_data};
    return o;
  endfunction

  function automatic vec_t mkLd(input logic [2:0] la, input logic [3:0] ld);
    vec_t v;
    v = '0;
    v.do_ld = 1'b1;
    v.la = la;
    v.ld = ld;
    return v;
  endfunction

  function automatic vec_t mkIns(input logic [1:0] op, input logic [2:0] dst, input logic [2:0] s0,
                                 input logic [2:0] s1, input logic [3:0] e0, input logic [3:0] e1,
                                 input logic [3:0] er);
    vec_t v;
    v = '0;
    v.do_ins = 1'b1;
    v.op = op; v.dst = dst; v.s0 = s0; v.s1 = s1;
    v.e0 = e0; v.e1 = e1; v.er = er;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic checkResetState(input int u, input logic want_ready);
    obs_t o;
    o = obs(u);
    checkOutput($sformatf("reset instr_ready u%0d", u), o.ready, want_ready);
    checkOutput($sformatf("reset alu_enable u%0d", u), o.enable, 0);
    checkOutput($sformatf("reset alu_op_code u%0d", u), o.op_code, 0);
    checkOutput($sformatf("reset alu_op0 u%0d", u), o.op0, 0);
    checkOutput($sformatf("reset alu_op1 u%0d", u), o.op1, 0);
    checkOutput($sformatf("reset res_valid u%0d", u), o.res_valid, 0);
    checkOutput($sformatf("reset res_dst u%0d", u), o.res_dst, 0);
    checkOutput($sformatf("reset res_data u%0d", u), o.res_data, 0);
  endtask

  task automatic loadReg(input int u, input logic [2:0] a, input logic [3:0] d);
    @(negedge clk);
    drv[u].ld_en = 1'b1;
    drv[u].ld_addr = a;
    drv[u].ld_data = d;
    @(negedge clk);
    drv[u].ld_en = 1'b0;
  endtask

  task automatic waitDrain(input int u);
    int n;
    obs_t o;
    n = 0;
    o = obs(u);
    while ((sb.size() != 0 || o.ready !== 1'b1) && n < 60) begin
      @(negedge clk);
      n++;
      o = obs(u);
    end
    if (sb.size() != 0 || o.ready !== 1'b1) checkOutput("drain timeout", sb.size(), 0);
  endtask

  // Offers one instruction, returns at the negedge of the first WAIT cycle.
  task automatic applyStimulus(input int u, input logic [1:0] op, input logic [2:0] dst,
                               input logic [2:0] s0, input logic [2:0] s1,
                               input logic [3:0] e_op0, input logic [3:0] e_op1, input logic [3:0] e_res,
                               input bit hold, input bit with_ld, input logic [2:0] la,
                               input logic [3:0] ld, input bit expect_res);
    int n;
    int lat;
    exp_t e;
    obs_t o;
    lat = (u == 0) ? 1 : 3;
    n = 0;
    @(negedge clk);
    drv[u].op = op;
    drv[u].dst = dst;
    drv[u].s0 = s0;
    drv[u].s1 = s1;
    drv[u].valid = 1'b1;
    o = obs(u);
    while (o.ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
      o = obs(u);
    end
    if (o.ready !== 1'b1) begin
      checkOutput("ready timeout", o.ready, 1);
      drv[u].valid = 1'b0;
      return;
    end
    if (with_ld) begin
      drv[u].ld_en = 1'b1;
      drv[u].ld_addr = la;
      drv[u].ld_data = ld;
    end
    last_acc = cycle + 1;
    if (expect_res) begin
      e.unit = u;
      e.dst = 32'(dst);
      e.data = 32'(e_res);
      e.due = last_acc + 1 + lat;
      sb.push_back(e);
    end
    @(negedge clk);
    if (with_ld) drv[u].ld_en = 1'b0;
    if (!hold) drv[u].valid = 1'b0;
    o = obs(u);
    checkOutput("issue alu_enable", o.enable, 1);
    checkOutput("issue alu_op_code", o.op_code, op);
    checkOutput("issue alu_op0", o.op0, e_op0);
    checkOutput("issue alu_op1", o.op1, e_op1);
    checkOutput("issue instr_ready", o.ready, 0);
    @(negedge clk);
    o = obs(u);
    checkOutput("wait alu_enable", o.enable, 0);
    checkOutput("wait alu_op0 hold", o.op0, e_op0);
    checkOutput("wait instr_ready", o.ready, 0);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cycle++;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d checks, %0d failures", n_checks, n_fail);
    $fatal(1, "[TB] watchdog expired");
  end

  // Result monitor: every res_valid pulse must match the oldest expected result.
  initial begin
    obs_t o;
    exp_t e;
    forever begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        o = obs(u);
        if (o.res_valid === 1'b1) begin
          if (sb.size() == 0 || sb[0].unit != u) begin
            checkOutput($sformatf("unexpected res_valid u%0d", u), 1, 0);
          end else begin
            e = sb.pop_front();
            checkOutput("res_dst", o.res_dst, e.dst);
            checkOutput("res_data", o.res_data, e.data);
            checkOutput("res_valid cycle", cycle, e.due);
          end
        end
      end
    end
  end

  initial begin
    vec_t vecs [15];
    int   acc_prev;

    reset = 1'b1;
    drv[0] = '0;
    drv[1] = '0;

    vecs[0]  = mkLd(3'd0, 4'd3);
    vecs[1]  = mkLd(3'd1, 4'd5);
    vecs[2]  = mkIns(OP_ADD, 3'd2, 3'd0, 3'd1, 4'd3,  4'd5,  4'd8);
    vecs[3]  = mkIns(OP_OR,  3'd3, 3'd2, 3'd2, 4'd8,  4'd8,  4'd8);
    vecs[4]  = mkLd(3'd0, 4'd15);
    vecs[5]  = mkLd(3'd1, 4'd1);
    vecs[6]  = mkIns(OP_ADD, 3'd0, 3'd0, 3'd1, 4'd15, 4'd1,  4'd0);
    vecs[7]  = mkIns(OP_SUB, 3'd1, 3'd0, 3'd1, 4'd0,  4'd1,  4'd15);
    vecs[8]  = mkLd(3'd2, 4'd10);
    vecs[9]  = mkIns(OP_AND, 3'd3, 3'd1, 3'd2, 4'd15, 4'd10, 4'd10);
    vecs[10] = mkLd(3'd3, 4'd5);
    vecs[11] = mkIns(OP_OR,  3'd3, 3'd2, 3'd3, 4'd10, 4'd5,  4'd15);
    vecs[12] = mkIns(OP_SUB, 3'd0, 3'd3, 3'd2, 4'd15, 4'd10, 4'd5);
    vecs[13] = mkIns(OP_ADD, 3'd1, 3'd0, 3'd0, 4'd5,  4'd5,  4'd10);
    vecs[13].do_ld = 1'b1;
    vecs[13].la = 3'd0;
    vecs[13].ld = 4'd7;
    vecs[14] = mkIns(OP_OR,  3'd2, 3'd0, 3'd0, 4'd7,  4'd7,  4'd7);

    repeat (2) @(negedge clk);
    for (int u = 0; u < 2; u++) checkResetState(u, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    for (int u = 0; u < 2; u++) checkResetState(u, 1'b1);

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].do_ins) begin
        applyStimulus(0, vecs[i].op, vecs[i].dst, vecs[i].s0, vecs[i].s1, vecs[i].e0, vecs[i].e1,
                      vecs[i].er, 1'b0, vecs[i].do_ld, vecs[i].la, vecs[i].ld, 1'b1);
      end else begin
        waitDrain(0);
        loadReg(0, vecs[i].la, vecs[i].ld);
      end
    end
    waitDrain(0);

    $display("[TB] back-to-back instructions with instr_valid held high");
    applyStimulus(0, OP_ADD, 3'd0, 3'd1, 3'd2, 4'd10, 4'd7, 4'd1, 1'b1, 1'b0, 3'd0, 4'd0, 1'b1);
    acc_prev = last_acc;
    applyStimulus(0, OP_ADD, 3'd3, 3'd0, 3'd0, 4'd1, 4'd1, 4'd2, 1'b1, 1'b0, 3'd0, 4'd0, 1'b1);
    checkOutput("b2b accept spacing 1", last_acc - acc_prev, 4);
    acc_prev = last_acc;
    applyStimulus(0, OP_SUB, 3'd2, 3'd3, 3'd0, 4'd2, 4'd1, 4'd1, 1'b0, 1'b0, 3'd0, 4'd0, 1'b1);
    checkOutput("b2b accept spacing 2", last_acc - acc_prev, 4);
    waitDrain(0);

    $display("[TB] load/write-back collision");
    loadReg(0, 3'd0, 4'd2);
    loadReg(0, 3'd1, 4'd4);
    applyStimulus(0, OP_ADD, 3'd2, 3'd0, 3'd1, 4'd2, 4'd4, 4'd6, 1'b0, 1'b0, 3'd0, 4'd0, 1'b1);
    drv[0].ld_en = 1'b1;
    drv[0].ld_addr = 3'd2;
    drv[0].ld_data = 4'd9;
    @(negedge clk);
    drv[0].ld_en = 1'b0;
    applyStimulus(0, OP_ADD, 3'd2, 3'd0, 3'd1, 4'd2, 4'd4, 4'd6, 1'b0, 1'b0, 3'd0, 4'd0, 1'b1);
    drv[0].ld_en = 1'b1;
    drv[0].ld_addr = 3'd3;
    drv[0].ld_data = 4'd9;
    @(negedge clk);
    drv[0].ld_en = 1'b0;
    applyStimulus(0, OP_OR, 3'd0, 3'd2, 3'd2, 4'd6, 4'd6, 4'd6, 1'b0, 1'b0, 3'd0, 4'd0, 1'b1);
    applyStimulus(0, OP_OR, 3'd1, 3'd3, 3'd3, 4'd9, 4'd9, 4'd9, 1'b0, 1'b0, 3'd0, 4'd0, 1'b1);
    waitDrain(0);

    $display("[TB] reset during WAIT");
    applyStimulus(0, OP_ADD, 3'd0, 3'd1, 3'd1, 4'd9, 4'd9, 4'd2, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    checkResetState(0, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    checkResetState(0, 1'b1);
    for (int r = 0; r < 4; r++) begin
      applyStimulus(0, OP_OR, 3'(r), 3'(r), 3'(r), 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 3'd0, 4'd0, 1'b1);
    end
    waitDrain(0);

    $display("[TB] latency-3, 8-register build");
    for (int i = 0; i < 8; i++) loadReg(1, 3'(i), 4'(i + 1));
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, OP_OR, 3'(i), 3'(i), 3'(i), 4'(i + 1), 4'(i + 1), 4'(i + 1),
                    1'b0, 1'b0, 3'd0, 4'd0, 1'b1);
    end
    applyStimulus(1, OP_ADD, 3'd0, 3'd7, 3'd6, 4'd8, 4'd7, 4'd15, 1'b0, 1'b0, 3'd0, 4'd0, 1'b1);
    waitDrain(1);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Command-side initiator for the `alu` block. It accepts register-to-register instructions over a valid/ready handshake and holds operands in a small internal register file. For each instruction it drives the ALU's `enable`/`op_code`/`op0`/`op1`, waits the fixed ALU latency, then writes the ALU `out` back to the destination register and reports the result. It sits between the instruction source (test harness or future decoder) and one `alu` instance.

## Interface
- `DATA_WIDTH`, 4, operand/result width; matches the ALU.
- `OPCODE_WIDTH`, 2, op code width; matches the ALU.
- `NUM_REGS`, 4, register file depth; power of two, ≥2.
- `ALU_LATENCY`, 1, cycles from the ALU enable cycle to valid `out`; ≥1.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `instr_valid`  in  1  instruction offered.
- `instr_ready`  out  1  sequencer can accept.
- `instr_op`  in  OPCODE_WIDTH  ALU op code, passed through unmodified.
- `instr_dst`, `instr_src0`, `instr_src1`  in  clog2(NUM_REGS) each  register indices.
- `ld_en`  in  1  direct register load strobe.
- `ld_addr`  in  clog2(NUM_REGS)  load index.
- `ld_data`  in  DATA_WIDTH  load value.
- `alu_enable`  out  1  to ALU `enable`.
- `alu_op_code`  out  OPCODE_WIDTH  to ALU `op_code`.
- `alu_op0`, `alu_op1`  out  DATA_WIDTH  to ALU `op0`/`op1`.
- `alu_out`  in  DATA_WIDTH  from ALU `out`.
- `res_valid`  out  1  one-cycle pulse; result committed.
- `res_dst`  out  clog2(NUM_REGS)  destination of committed result.
- `res_data`  out  DATA_WIDTH  committed result value.

## Operation
- FSM states: IDLE → ISSUE → WAIT → COMMIT → IDLE.
- **IDLE:** `instr_ready`=1. When `instr_valid & instr_ready` is high, latch op, dst, and the register values of src0/src1, then go to ISSUE.
- **ISSUE:** lasts 1 cycle. `alu_enable`=1; `alu_op_code`/`alu_op0`/`alu_op1` carry the latched values. Go to WAIT.
- **WAIT:** `alu_enable`=0 and operand outputs hold their values. A counter runs ALU_LATENCY cycles. In the last WAIT cycle, `alu_out` is sampled, written to `regs[dst]`, and captured into `res_data`. Go to COMMIT.
- **COMMIT:** lasts 1 cycle. `res_valid`=1, `res_dst`/`res_data` are valid, and `instr_ready`=0. Go to IDLE.
- **Operand snapshot:** src0 = src1 and src = dst are legal. Operands come from the snapshot taken at acceptance.
- **Load port:** `ld_en` writes `regs[ld_addr]` in any state.
  - If the WAIT write-back and `ld_en` target the same register in the same cycle, the write-back wins.
  - If a load and an instruction acceptance occur in the same cycle, the operand snapshot sees pre-load values.
- Widths are fixed: no sign or width conversion. `alu_out` is taken verbatim.
- **Reset:** all registers become 0. FSM returns to IDLE from any state. An in-flight instruction is dropped with no write-back and no `res_valid`.
- Reset values of outputs: `instr_ready`=1 (in the cycle after reset deasserts; 0 while reset is held), `alu_enable`=0, `alu_op_code`/`alu_op0`/`alu_op1`=0, `res_valid`=0, `res_dst`=0, `res_data`=0.

## Timing
- Acceptance edge ends cycle T.
- ISSUE occupies cycle T+1.
- WAIT occupies T+2 … T+1+ALU_LATENCY.
- `res_valid` is high in cycle T+2+ALU_LATENCY. `instr_ready` returns in T+3+ALU_LATENCY.
- Throughput: one instruction per ALU_LATENCY+3 cycles. No pipelining.
- A committed value is visible to an instruction accepted in the cycle after COMMIT.
- All outputs are registered.

## Structure
- Shared package `alu_pkg` holds the FSM state enum, and `DATA_WIDTH`/`OPCODE_WIDTH` defaults shared with `alu`.
- Sub-module `alu_regfile` provides NUM_REGS×DATA_WIDTH storage:
  - two combinational read ports;
  - one write port with write-back priority over the load port;
  - synchronous reset to 0.
- The FSM and latency counter stay in the top module.

## Test plan
The bench connects a behavioural ALU model: op 0 = ADD mod 2^W, op 1 = SUB, op 2 = AND, op 3 = OR, ALU_LATENCY=1.
- **ADD:** load r0=3, r1=5; issue ADD r2←r0,r1 → `alu_enable` for exactly 1 cycle with op0=3, op1=5. `res_valid` appears 3 cycles after acceptance with `res_dst`=2, `res_data`=8; r2=8.
- **Wrap-around:** r0=15, r1=1, ADD r0←r0,r1 → `res_data`=0, r0=0. Then SUB r1←r0,r1 → 0−1 = 15.
- **Back-to-back:** hold `instr_valid` high for 3 instructions → `instr_ready` low between them; each accepted exactly once, 4 cycles apart. Results are in order and the second instruction sees the first's result.
- **Collision:** `ld_en` to r2 with 9 in the write-back cycle of an instruction targeting r2 (result 6) → r2=6. A load to r3 in the same cycle → r3=9.
- **Reset mid-operation:** assert reset during WAIT → no `res_valid`, all regs=0, `instr_ready`=1 in the cycle after reset deasserts.
- **Parameter sweep:** ALU_LATENCY=3, NUM_REGS=8 → `res_valid` 5 cycles after acceptance; indices 0–7 are all addressable.
